alu_seq_divider: RTL
====================

// Module: alu_seq_divider
// PURPOSE
//  Multi-cycle unsigned restoring divider for the 8-bit ALU. Consumes the difference/borrow of
//  one ripple-borrow subtractor stage, once per clock, to build quotient and remainder over
//  DATA_WIDTH cycles. Sits beside the add/sub path; the ALU result mux reads quotient/remainder
//  when done is seen. Start/done handshake; operands are captured at start.
// PARAMETERS
//  DATA_WIDTH  default CPU_package::DATA_WIDTH (8)   operand/quotient/remainder width
//  CNT_W       default $clog2(DATA_WIDTH+1)          iteration counter width (localparam)
// PORTS
//  clk          in   1           system clock; all state updates on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  start        in   1           request; sampled only when busy=0
//  dividend     in   DATA_WIDTH  unsigned dividend, captured on accepted start
//  divisor      in   DATA_WIDTH  unsigned divisor, captured on accepted start
//  busy         out  1           high while state=RUN
//  done         out  1           one-cycle pulse; results valid in this cycle
//  quotient     out  DATA_WIDTH  registered quotient, held until next accepted start completes
//  remainder    out  DATA_WIDTH  registered remainder, held as quotient
//  div_by_zero  out  1           registered with results; high iff captured divisor==0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, quotient=0, remainder=0,
//   div_by_zero=0; counter, internal regs cleared. Reset mid-RUN aborts; no done follows.
//  States: IDLE, RUN, DONE (div_state_t).
//   IDLE: start=1 & divisor!=0 -> RUN: load q_sh=dividend, rem=0, dvs=divisor, cnt=0.
//         start=1 & divisor==0 -> DONE: quotient={DATA_WIDTH{1}}, remainder=dividend,
//         div_by_zero=1 (done visible 1 cycle after start edge).
//   RUN: one iteration per edge:
//     shifted = {rem, q_sh[MSB]} (DATA_WIDTH+1 bits); q_sh <<= 1.
//     Subtractor: a=shifted[DATA_WIDTH-1:0], b=dvs, Bin=0 -> D, B.
//     accept = shifted[DATA_WIDTH] | ~B. accept: rem=D, q_sh[0]=1; else rem=shifted low bits,
//       q_sh[0]=0.
//     cnt++. When cnt==DATA_WIDTH-1 (last iteration): register quotient/remainder from the
//       updated values, div_by_zero=0, -> DONE.
//   DONE: done=1 for exactly this cycle. start=1 here is accepted as from IDLE (back-to-back);
//     else -> IDLE.
//  Latency: start edge k -> done high in the cycle after edge k+DATA_WIDTH (8 clocks for 8-bit).
//  start while busy=1: ignored, operands not recaptured. Outputs change only on entry to DONE.
//  Invariant: dividend == quotient*divisor + remainder, remainder < divisor (divisor!=0).
//  Remainder register is DATA_WIDTH bits; the 9th bit of shifted is transient only.
// STRUCTURE
//  CPU_package: DATA_WIDTH, typedef enum logic [1:0] {IDLE,RUN,DONE} div_state_t.
//  One sub-module: Full_Subtractor_by8 (existing ripple-borrow subtractor), Bin tied 0,
//   instantiated once as the per-iteration trial subtractor; all other logic in this module.
//  Separate always_ff (async rst_n) for FSM/datapath; always_comb for next-state/accept.
// TESTING
//  100/7: start 1 cycle -> busy 8 cycles, done pulse 8 clk later, q=14 r=2 dz=0.
//  255/1 -> q=255 r=0; 5/200 -> q=0 r=5; 255/255 -> q=1 r=0; 200/3 -> q=66 r=2.
//  37/0 -> done 1 clk after start, q=8'hFF r=37 dz=1, busy never high.
//  start 100/7 then, at cycle 3 of RUN, start 9/3 -> ignored; result q=14 r=2.
//  Back-to-back: start 50/6, reassert start with 77/8 in done cycle -> q=8 r=2, then
//   second done 8 clk later q=9 r=5; done never held 2 cycles.
//  rst_n low at RUN cycle 4 -> all outputs 0 immediately; no done after release; new
//   start 10/3 -> q=3 r=1.
//  Random 10k unsigned pairs vs reference model incl. invariant check.

Source files
------------

// File: rtl/alu_seq_divider_pkg.sv
// Shared CPU definitions used by the ALU divider: datapath width and divider FSM states.
package CPU_package;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_seq_divider_sub.sv
// Ripple-borrow subtractor: d = a - b - bin, bout is the borrow out of the MSB.
module Full_Subtractor_by8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH:0] borrow_s;

  assign borrow_s[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign d[i]            = a[i] ^ b[i] ^ borrow_s[i];
    assign borrow_s[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_s[i]);
  end

  assign bout = borrow_s[WIDTH];

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, DATA_WIDTH iterations,
// start/done handshake with results and div_by_zero held until the next completed operation.
module alu_seq_divider
  import CPU_package::*;
#(
  parameter int DATA_WIDTH = CPU_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  div_state_t            state_r;
  logic [DATA_WIDTH-1:0] q_sh_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0]      cnt_r;

  logic [DATA_WIDTH:0]   shifted_s;
  logic [DATA_WIDTH-1:0] sub_a_s;
  logic [DATA_WIDTH-1:0] diff_s;
  logic                  borrow_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] rem_next_s;
  logic [DATA_WIDTH-1:0] q_next_s;
  logic                  divisor_zero_s;

  Full_Subtractor_by8 #(
    .WIDTH (DATA_WIDTH)
  ) u_trial_sub (
    .a    (sub_a_s),
    .b    (dvs_r),
    .bin  (1'b0),
    .d    (diff_s),
    .bout (borrow_s)
  );

  // Trial-subtraction decision and next partial remainder / quotient shift.
  always_comb begin
    shifted_s      = {rem_r, q_sh_r[DATA_WIDTH-1]};
    sub_a_s        = shifted_s[DATA_WIDTH-1:0];
    // A set 9th bit means the shifted value already exceeds any divisor, so the wrapped D is exact.
    accept_s       = shifted_s[DATA_WIDTH] | ~borrow_s;
    q_next_s       = {q_sh_r[DATA_WIDTH-2:0], accept_s};
    divisor_zero_s = (divisor == {DATA_WIDTH{1'b0}});
    if (accept_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shifted_s[DATA_WIDTH-1:0];
    end
  end

  // Divider FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      q_sh_r      <= {DATA_WIDTH{1'b0}};
      rem_r       <= {DATA_WIDTH{1'b0}};
      dvs_r       <= {DATA_WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {DATA_WIDTH{1'b0}};
      remainder   <= {DATA_WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start && divisor_zero_s) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {DATA_WIDTH{1'b1}};
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else if (start) begin
            state_r <= RUN;
            busy    <= 1'b1;
            q_sh_r  <= dividend;
            rem_r   <= {DATA_WIDTH{1'b0}};
            dvs_r   <= divisor;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          q_sh_r <= q_next_s;
          rem_r  <= rem_next_s;
          cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next_s;
            remainder   <= rem_next_s;
            div_by_zero <= 1'b0;
          end else begin
            state_r <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
